// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the wishbone bus arbiter.
//   arb_state_t : arbiter FSM states
//   wb_req_t    : request fields latched on the grant edge
//   SEL_ALL     : byte-select value driven for instruction fetches
package wb_arb_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;
    localparam int ARB_SEL_W  = 4;

    localparam logic [ARB_SEL_W-1:0] SEL_ALL = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_D,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] adr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_SEL_W-1:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of every non-clock signal around the arbiter.
//   Requester side : if_req/if_adr -> if_ack/if_err/if_instr
//                    d_req/d_we/d_adr/d_wdata/d_sel -> d_ack/d_err/d_rdata
//   Wishbone side  : cyc_out/stb_out/we_out/adr_out/data_out/sel_out -> data_in/akn_in
// modport master : the arbiter itself (it masters the wishbone bus)
// modport slave  : the surroundings (fetch unit, load/store unit, wishbone slave)
interface wb_bus_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int SEL_W  = ARB_SEL_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_adr;
    logic              if_ack;
    logic              if_err;
    logic [DATA_W-1:0] if_instr;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic [SEL_W-1:0]  d_sel;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;

    logic              cyc_out;
    logic              stb_out;
    logic              we_out;
    logic [ADDR_W-1:0] adr_out;
    logic [DATA_W-1:0] data_out;
    logic [SEL_W-1:0]  sel_out;
    logic [DATA_W-1:0] data_in;
    logic              akn_in;

    modport master (
        input  if_req, if_adr, d_req, d_we, d_adr, d_wdata, d_sel, data_in, akn_in,
        output if_ack, if_err, if_instr, d_ack, d_err, d_rdata,
        output cyc_out, stb_out, we_out, adr_out, data_out, sel_out
    );

    modport slave (
        output if_req, if_adr, d_req, d_we, d_adr, d_wdata, d_sel, data_in, akn_in,
        input  if_ack, if_err, if_instr, d_ack, d_err, d_rdata,
        input  cyc_out, stb_out, we_out, adr_out, data_out, sel_out
    );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr_i     : return the count to zero (takes priority over en_i)
//   en_i      : count one more cycle
//   expired_o : count has reached TIMEOUT-1 (never asserted when TIMEOUT is 0)
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares one wishbone master port between the instruction-fetch unit
// (read-only) and the load/store unit. Data requests win unless fetch has
// already waited through MAX_D_RUN consecutive data grants. A watchdog aborts
// any bus cycle that sees no acknowledge for TIMEOUT cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_bus_arbiter_if.master, requester and wishbone signals
// Every output is driven straight from a register.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W    = ARB_ADDR_W,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int SEL_W     = ARB_SEL_W,
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    wb_bus_arbiter_if.master bus
);

    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

    arb_state_t        state_q, state_d;
    wb_req_t           req_q, req_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              act_q, act_d;      // drives both cyc_out and stb_out
    logic              if_ack_q, if_ack_d;
    logic              if_err_q, if_err_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic in_bus;
    logic tmo_expired;

    assign in_bus = (state_q == BUS_IF) || (state_q == BUS_D);

    wb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!in_bus),
        .en_i     (in_bus),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        run_d      = run_q;
        act_d      = act_q;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        if_instr_d = if_instr_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.if_req && run_q == RUN_MAX)) begin
                    state_d   = BUS_D;
                    act_d     = 1'b1;
                    req_d.we  = bus.d_we;
                    req_d.adr = ARB_ADDR_W'(bus.d_adr);
                    req_d.wdata = ARB_DATA_W'(bus.d_wdata);
                    req_d.sel = ARB_SEL_W'(bus.d_sel);
                    // With fetch waiting, run_q is below RUN_MAX here, so
                    // the increment cannot overflow the saturation point.
                    run_d = bus.if_req ? run_q + RUN_W'(1) : '0;
                end else if (bus.if_req) begin
                    state_d     = BUS_IF;
                    act_d       = 1'b1;
                    req_d.we    = 1'b0;
                    req_d.adr   = ARB_ADDR_W'(bus.if_adr);
                    req_d.wdata = '0;
                    req_d.sel   = SEL_ALL;
                    run_d       = '0;
                end
            end

            BUS_IF, BUS_D: begin
                // Acknowledge is tested first so it wins over a same-edge expiry.
                if (bus.akn_in) begin
                    state_d = DONE;
                    act_d   = 1'b0;
                    if (state_q == BUS_IF) begin
                        if_ack_d   = 1'b1;
                        if_instr_d = bus.data_in;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!req_q.we) begin
                            d_rdata_d = bus.data_in;
                        end
                    end
                end else if (tmo_expired) begin
                    state_d = DONE;
                    act_d   = 1'b0;
                    if (state_q == BUS_IF) begin
                        if_err_d = 1'b1;
                    end else begin
                        d_err_d = 1'b1;
                    end
                end
            end

            // Requests are not looked at here: the requester is still seeing
            // its ack/err and may not have dropped req yet.
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            run_q      <= '0;
            act_q      <= 1'b0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            if_instr_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            run_q      <= run_d;
            act_q      <= act_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            if_instr_q <= if_instr_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.cyc_out  = act_q;
    assign bus.stb_out  = act_q;
    assign bus.we_out   = req_q.we;
    assign bus.adr_out  = ADDR_W'(req_q.adr);
    assign bus.data_out = DATA_W'(req_q.wdata);
    assign bus.sel_out  = SEL_W'(req_q.sel);
    assign bus.if_ack   = if_ack_q;
    assign bus.if_err   = if_err_q;
    assign bus.if_instr = if_instr_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter (MAX_D_RUN = 4, TIMEOUT = 8).
module tb_wb_bus_arbiter;

    localparam logic [15:0] PAT = 16'h5A5A;

    typedef struct packed {
        logic        is_d;
        logic        is_err;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    logic [15:0] m_instr   = 16'h0000;
    logic [15:0] m_d_rdata = 16'h0000;

    wb_bus_arbiter_if #(.ADDR_W(16), .DATA_W(16), .SEL_W(4)) bi ();

    wb_bus_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .SEL_W    (4),
        .MAX_D_RUN(4),
        .TIMEOUT  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [74:0] all_outs();
        return {bi.cyc_out, bi.stb_out, bi.we_out, bi.adr_out, bi.data_out, bi.sel_out,
                bi.if_ack, bi.if_err, bi.if_instr, bi.d_ack, bi.d_err, bi.d_rdata};
    endfunction

    // Drives one transaction, plays the wishbone slave (ack after wait_n
    // stalled cycles, never when wait_n < 0) and reports what it observed.
    task automatic xfer(input logic is_d, input logic we, input logic [15:0] adr,
                        input logic [15:0] wdat, input logic [3:0] sel, input int wait_n,
                        input logic [15:0] rdat, output int lat, output int n_stb,
                        output logic stable, output logic got_ack, output logic got_err,
                        output logic stray, output logic [15:0] rd, output exp_t e,
                        output logic hung);
        logic fin;
        fin = 1'b0; lat = 0; n_stb = 0; stable = 1'b1; got_ack = 1'b0; got_err = 1'b0;
        stray = 1'b0; rd = '0; e = '0; hung = 1'b1;
        if (is_d) begin
            bi.d_req = 1'b1; bi.d_we = we; bi.d_adr = adr; bi.d_wdata = wdat; bi.d_sel = sel;
        end else begin
            bi.if_req = 1'b1; bi.if_adr = adr;
        end
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            bi.akn_in  = 1'b0;
            bi.data_in = ~rdat;
            if (bi.stb_out) begin
                n_stb++;
                if (n_stb == 1) lat = c + 1;
                if ({bi.cyc_out, bi.we_out, bi.adr_out, bi.sel_out} !==
                    {1'b1, is_d & we, adr, is_d ? sel : 4'hF}) stable = 1'b0;
                if (is_d && bi.data_out !== wdat) stable = 1'b0;
                if (n_stb == 2) begin
                    bi.if_adr = ~adr; bi.d_adr = ~adr; bi.d_wdata = ~wdat;
                    bi.d_we = ~we; bi.d_sel = ~sel;
                end
                if (wait_n >= 0 && n_stb > wait_n) begin
                    bi.akn_in  = 1'b1;
                    bi.data_in = rdat;
                end
            end
            if (is_d ? (bi.if_ack | bi.if_err) : (bi.d_ack | bi.d_err)) stray = 1'b1;
            if (is_d ? (bi.d_ack | bi.d_err) : (bi.if_ack | bi.if_err)) begin
                got_ack = is_d ? bi.d_ack : bi.if_ack;
                got_err = is_d ? bi.d_err : bi.if_err;
                rd      = is_d ? bi.d_rdata : bi.if_instr;
                if (sb.size() != 0) e = sb.pop_front();
                bi.if_req = 1'b0; bi.d_req = 1'b0;
                hung = 1'b0; fin = 1'b1;
                @(negedge clk);
                if (bi.if_ack | bi.if_err | bi.d_ack | bi.d_err | bi.cyc_out | bi.stb_out)
                    stray = 1'b1;
            end
        end
        bi.if_req = 1'b0; bi.d_req = 1'b0; bi.akn_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs());
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        int lat, n_stb; logic st, ack, err, stray, hung; logic [15:0] rd; exp_t e;
        sb.push_back('{is_d: 1'b0, is_err: 1'b0, data: 16'hA5C3});
        xfer(1'b0, 1'b0, 16'h0040, 16'h0000, 4'h0, 0, 16'hA5C3,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL fetch_latency: got %0d, want 1", lat); end
        n_checks++; if (n_stb != 1) begin n_fail++; $display("FAIL fetch_stb_cycles: got %0d, want 1", n_stb); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL fetch_bus_fields: got unstable/wrong, want adr 0040 we 0 sel F"); end
        n_checks++; if ({hung, ack, err} !== {1'b0, 1'b1, e.is_err}) begin n_fail++; $display("FAIL fetch_ack: got hung=%b ack=%b err=%b, want 0 1 0", hung, ack, err); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL fetch_instr: got %h, want %h", rd, e.data); end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_width: got extra pulse/bus activity, want none"); end
        m_instr = 16'hA5C3;
    endtask

    task automatic test_write();
        int lat, n_stb; logic st, ack, err, stray, hung; logic [15:0] rd; exp_t e;
        sb.push_back('{is_d: 1'b1, is_err: 1'b0, data: m_d_rdata});
        xfer(1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'h3, 3, 16'h7777,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL write_latency: got %0d, want 1", lat); end
        n_checks++; if (n_stb != 4) begin n_fail++; $display("FAIL write_stb_cycles: got %0d, want 4", n_stb); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL write_bus_stable: got unstable/wrong, want 1234/BEEF/3 we=1"); end
        n_checks++; if ({hung, ack, err} !== {1'b0, 1'b1, e.is_err}) begin n_fail++; $display("FAIL write_ack: got hung=%b ack=%b err=%b, want 0 1 0", hung, ack, err); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL write_rdata_kept: got %h, want %h", rd, e.data); end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL write_pulse_width: got extra pulse/bus activity, want none"); end
    endtask

    task automatic test_arbitration();
        logic exp_d [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   grants = 0;
        int   dones  = 0;
        logic prev_stb = 1'b0;
        logic kind;
        exp_t e;
        for (int i = 0; i < 10; i++)
            sb.push_back('{is_d: exp_d[i], is_err: 1'b0,
                           data: exp_d[i] ? (16'h2000 ^ PAT) : (16'h0100 ^ PAT)});
        bi.if_req = 1'b1; bi.if_adr = 16'h0100;
        bi.d_req = 1'b1; bi.d_we = 1'b0; bi.d_adr = 16'h2000; bi.d_wdata = 16'h0; bi.d_sel = 4'hF;
        for (int c = 0; c < 80 && dones < 10; c++) begin
            @(negedge clk);
            bi.akn_in = 1'b0;
            if (bi.stb_out && !prev_stb) begin
                kind = (bi.adr_out == 16'h2000);
                n_checks++;
                if (grants >= 10 || kind !== exp_d[grants]) begin
                    n_fail++;
                    $display("FAIL grant_order[%0d]: got %s, want %s", grants,
                             kind ? "D" : "IF", (grants < 10 && exp_d[grants]) ? "D" : "IF");
                end
                grants++;
            end
            if (bi.stb_out) begin
                bi.akn_in  = 1'b1;
                bi.data_in = bi.adr_out ^ PAT;
            end
            prev_stb = bi.stb_out;
            if (bi.if_ack || bi.d_ack) begin
                e = sb.pop_front();
                n_checks++;
                if (bi.d_ack !== e.is_d || bi.if_ack === e.is_d ||
                    (bi.d_ack ? bi.d_rdata : bi.if_instr) !== e.data) begin
                    n_fail++;
                    $display("FAIL arb_done[%0d]: got d_ack=%b if_ack=%b data=%h, want d=%b data=%h",
                             dones, bi.d_ack, bi.if_ack, bi.d_ack ? bi.d_rdata : bi.if_instr,
                             e.is_d, e.data);
                end
                dones++;
                if (dones == 10) begin bi.if_req = 1'b0; bi.d_req = 1'b0; end
            end
        end
        n_checks++;
        if (dones != 10) begin n_fail++; $display("FAIL arb_completions: got %0d, want 10", dones); end
        bi.if_req = 1'b0; bi.d_req = 1'b0; bi.akn_in = 1'b0;
        sb.delete();
        m_d_rdata = 16'h2000 ^ PAT;
        m_instr   = 16'h0100 ^ PAT;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat, n_stb; logic st, ack, err, stray, hung; logic [15:0] rd; exp_t e;
        sb.push_back('{is_d: 1'b1, is_err: 1'b1, data: m_d_rdata});
        xfer(1'b1, 1'b0, 16'h3000, 16'h0000, 4'hF, -1, 16'h9999,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if (n_stb != 8) begin n_fail++; $display("FAIL tmo_stb_cycles: got %0d, want 8", n_stb); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL tmo_bus_stable: got unstable/wrong, want 3000 read"); end
        n_checks++; if ({hung, ack, err} !== {1'b0, 1'b0, e.is_err}) begin n_fail++; $display("FAIL tmo_err: got hung=%b ack=%b err=%b, want 0 0 1", hung, ack, err); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL tmo_rdata_kept: got %h, want %h", rd, e.data); end
        n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got extra pulse/bus activity, want none"); end
        sb.push_back('{is_d: 1'b1, is_err: 1'b0, data: 16'h1357});
        xfer(1'b1, 1'b0, 16'h3002, 16'h0000, 4'hF, 0, 16'h1357,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if ({hung, ack, err, lat} !== {1'b0, 1'b1, e.is_err, 32'd1}) begin n_fail++; $display("FAIL after_tmo_ack: got hung=%b ack=%b err=%b lat=%0d, want 0 1 0 1", hung, ack, err, lat); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL after_tmo_rdata: got %h, want %h", rd, e.data); end
        m_d_rdata = 16'h1357;
    endtask

    task automatic test_ack_on_expiry();
        int lat, n_stb; logic st, ack, err, stray, hung; logic [15:0] rd; exp_t e;
        sb.push_back('{is_d: 1'b1, is_err: 1'b0, data: 16'h2468});
        xfer(1'b1, 1'b0, 16'h4000, 16'h0000, 4'hF, 7, 16'h2468,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if (n_stb != 8) begin n_fail++; $display("FAIL expiry_stb_cycles: got %0d, want 8", n_stb); end
        n_checks++; if ({hung, ack, err} !== {1'b0, 1'b1, e.is_err}) begin n_fail++; $display("FAIL expiry_ack_wins: got hung=%b ack=%b err=%b, want 0 1 0", hung, ack, err); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL expiry_rdata: got %h, want %h", rd, e.data); end
        m_d_rdata = 16'h2468;
    endtask

    task automatic test_stray_ack();
        int lat, n_stb; logic st, ack, err, stray, hung; logic [15:0] rd; exp_t e;
        logic quiet = 1'b1;
        bi.akn_in = 1'b1; bi.data_in = 16'hFFFF;
        repeat (4) begin
            @(negedge clk);
            if (bi.if_ack | bi.if_err | bi.d_ack | bi.d_err | bi.cyc_out | bi.stb_out |
                (bi.if_instr !== m_instr) | (bi.d_rdata !== m_d_rdata)) quiet = 1'b0;
        end
        bi.akn_in = 1'b0;
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL stray_ack_idle: got pulse or change, want none"); end
        sb.push_back('{is_d: 1'b0, is_err: 1'b0, data: 16'h0F0F});
        xfer(1'b0, 1'b0, 16'h0080, 16'h0000, 4'h0, 1, 16'h0F0F,
             lat, n_stb, st, ack, err, stray, rd, e, hung);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL stray_then_latency: got %0d, want 1", lat); end
        n_checks++; if ({hung, ack, err, n_stb} !== {1'b0, 1'b1, e.is_err, 32'd2}) begin n_fail++; $display("FAIL stray_then_fetch: got hung=%b ack=%b err=%b stb=%0d, want 0 1 0 2", hung, ack, err, n_stb); end
        n_checks++; if (rd !== e.data) begin n_fail++; $display("FAIL stray_then_instr: got %h, want %h", rd, e.data); end
        m_instr = 16'h0F0F;
    endtask

    task automatic test_reset_mid();
        logic quiet = 1'b1;
        bi.d_req = 1'b1; bi.d_we = 1'b0; bi.d_adr = 16'h5000; bi.d_sel = 4'hF; bi.akn_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bi.stb_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got stb %b, want 1", bi.stb_out); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (all_outs() !== '0) begin n_fail++; $display("FAIL rstmid_outputs: got %h, want 0", all_outs()); end
        rst = 1'b0; bi.d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bi.d_ack | bi.d_err | bi.if_ack | bi.if_err | bi.cyc_out) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL rstmid_quiet: got pulse or cycle, want none"); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bi.if_req = 1'b0; bi.if_adr = '0;
        bi.d_req = 1'b0; bi.d_we = 1'b0; bi.d_adr = '0; bi.d_wdata = '0; bi.d_sel = '0;
        bi.data_in = '0; bi.akn_in = 1'b0;
        test_reset();
        test_fetch();
        test_write();
        test_arbitration();
        test_timeout();
        test_ack_on_expiry();
        test_stray_ack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the CPU's single 16-bit wishbone master port between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Sits between the CPU core and the wishbone interconnect.
- Arbitration: data has priority, with a starvation guard for fetch.
- Adds a bus-timeout watchdog so a missing acknowledge cannot hang the core.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- SEL_W, 4, byte-select width.
- MAX_D_RUN, 4, maximum consecutive data grants while fetch is pending.
- TIMEOUT, 255, cycles without wb_ack_i before the cycle is aborted. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, level, held until if_ack or if_err
- if_adr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_err  out  1  one-cycle fetch timeout pulse
- if_instr  out  DATA_W  fetched instruction, valid with if_ack
- d_req  in  1  data request, level, held until d_ack or d_err
- d_we  in  1  data direction: 1 write, 0 read
- d_adr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_sel  in  SEL_W  byte selects
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  one-cycle data timeout pulse
- d_rdata  out  DATA_W  read data, valid with d_ack
- cyc_out  out  1  wishbone cycle
- stb_out  out  1  wishbone strobe
- we_out  out  1  wishbone write enable, low = read
- adr_out  out  ADDR_W  wishbone address
- data_out  out  DATA_W  wishbone write data
- sel_out  out  SEL_W  wishbone byte selects
- data_in  in  DATA_W  wishbone read data
- akn_in  in  1  wishbone acknowledge

Behaviour:
- Reset: synchronous, active-high, sampled on rising clk.
  - Returns the block to IDLE and clears the run counter and timeout counter.
  - All outputs are registered. All are 0 after reset, including if_instr and d_rdata.
- States: IDLE, BUS_IF, BUS_D, DONE.
- IDLE:
  - Both requests low: stay in IDLE.
  - d_req only: go to BUS_D.
  - if_req only: go to BUS_IF.
  - Both requests high: go to BUS_D, unless run_cnt == MAX_D_RUN, in which case go to BUS_IF.
- Grant and latch:
  - The granted request's adr, we, wdata and sel are latched on the grant edge.
  - Fetch grants drive we_out = 0 and sel_out = all ones.
  - cyc_out and stb_out are asserted in the first BUS_x cycle: one cycle after the request is seen in IDLE.
- BUS_x, acknowledge:
  - Outputs hold stable until akn_in is sampled high.
  - On that edge: cyc_out and stb_out drop, read data_in is captured into if_instr or d_rdata, the matching ack pulses for exactly the next cycle, and the state moves to DONE.
- BUS_x, timeout:
  - tmo_cnt increments every BUS_x cycle.
  - When tmo_cnt == TIMEOUT-1 and akn_in is low: abort, drop cyc_out and stb_out, leave the read data register unchanged, pulse the matching err, go to DONE.
  - akn_in and timeout on the same edge: the ack wins.
- DONE:
  - Lasts exactly one cycle, during which ack or err is high.
  - Always goes to IDLE.
  - The requester must drop req, or present a new transaction, in the cycle after ack/err.
  - The arbiter ignores req during DONE, which prevents a double issue.
- Minimum transaction: IDLE → BUS → DONE = 3 cycles with zero-wait ack. Back-to-back throughput is one transfer per 3 cycles.
- run_cnt:
  - Increments on each data grant made while if_req is high, saturating at MAX_D_RUN.
  - Clears on any fetch grant, and on any data grant made while if_req is low.
- akn_in outside BUS_x is ignored.
- Reset mid-transaction: cyc_out and stb_out are deasserted on the next edge, and no ack or err is issued.
- Requester inputs that change while granted are ignored.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum arb_state_t {IDLE, BUS_IF, BUS_D, DONE};
  - the localparam for all-ones sel;
  - the struct wb_req_t {we, adr, wdata, sel} used for the latched request.
- One sub-module, wb_timeout_cnt: a counter with clear and enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
1. Fetch only: if_req = 1, if_adr = 16'h0040; slave acks one cycle after stb with data_in = 16'hA5C3.
   - Required: stb_out high in cycle 1, adr_out = 16'h0040, we_out = 0, sel_out = 4'hF.
   - Required: if_ack pulses one cycle with if_instr = 16'hA5C3.
2. Data write: d_req = 1, d_we = 1, d_adr = 16'h1234, d_wdata = 16'hBEEF, d_sel = 4'h3; ack after 3 wait cycles.
   - Required: bus signals stable for all 4 BUS cycles, then d_ack pulses; d_rdata unchanged.
3. Simultaneous requests, both held continuously, MAX_D_RUN = 4.
   - Required: grant order D, D, D, D, IF, D, …
   - Required: fetch is never starved beyond 4 data grants.
4. No ack, TIMEOUT = 8.
   - Required: stb_out high for exactly 8 cycles, then d_err pulses one cycle; d_ack never rises; the next request is served normally.
5. rst asserted in the second cycle of BUS_D.
   - Required: cyc_out = stb_out = 0 on the next edge, no d_ack or d_err, all outputs 0.
6. akn_in asserted on the same edge as timeout expiry.
   - Required: ack issued, err not issued, read data captured.
7. Stray akn_in while in IDLE.
   - Required: no ack or err pulse, no state change.
